ahb_crypt_slave: RTL and testbench

AHB_CRYPT_SLAVE -- requirements
Module: ahb_crypt_slave

---
 rtl/ahb_crypt_slave.sv | 138 +++++++++++++
 tb/tb_ahb_crypt_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_crypt_slave.sv
// ahb_crypt_slave: AHB-Lite register slave feeding a cipher core through input/output FIFOs
module ahb_crypt_fifo #(
  parameter int W = 64,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(D+1)-1:0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
  always_ff @(posedge clk)
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign rdata = mem[rp];
  assign full = (count == CW'(D));
  assign empty = (count == '0);
endmodule

module ahb_crypt_slave #(
  parameter int DATA_W = 64,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              enc_dec,
  output logic [DATA_W-1:0] key1,
  output logic [DATA_W-1:0] key2,
  output logic [DATA_W-1:0] key3,
  output logic              key_load,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [DATA_W-1:0] core_out_data
);
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  typedef enum logic {S_OK, S_ERR} state_t;
  state_t state, state_nx;
  logic ph_valid, ph_write;
  logic [4:0] ph_reg;
  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  logic in_full, in_empty, out_full, out_empty, underflow;
  logic [DATA_W-1:0] out_head;
  logic wr, rd, wr_ctrl, wr_key, wr_din, rd_dout, clr;
  logic in_push, in_pop, out_push, out_pop, err_hit;
  logic [18:0] status;
  logic unused;
  assign unused = ^{HSIZE, HADDR[31:15], HADDR[9:0], HTRANS[0]};
  assign wr = ph_valid & ph_write;
  assign rd = ph_valid & ~ph_write;
  assign wr_ctrl = wr & (ph_reg == 5'd0);
  assign wr_key = wr & (ph_reg inside {5'd1, 5'd2, 5'd3});
  assign wr_din = wr & (ph_reg == 5'd4);
  // the second cycle of an ERROR response must not re-evaluate the FIFO state
  assign rd_dout = rd & (ph_reg == 5'd5) & (state == S_OK);
  assign clr = wr_ctrl & HWDATA[1];
  assign in_pop = core_in_valid & core_in_ready;
  assign in_push = wr_din & (~in_full | in_pop);
  assign out_push = core_out_valid & core_out_ready;
  assign out_pop = rd_dout & ~out_empty;
  assign err_hit = rd_dout & out_empty;
  assign core_in_valid = ~in_empty;
  assign core_out_ready = ~out_full;
  assign status = {underflow, out_empty, in_full, 8'(out_cnt), 8'(in_cnt)};
  assign HRDATA = out_pop ? out_head
                : (rd & (ph_reg == 5'd6)) ? DATA_W'(status)
                : (rd & (ph_reg == 5'd0)) ? DATA_W'(enc_dec) : '0;
  always_ff @(posedge HCLK) state <= HRESET ? S_OK : state_nx;
  always_comb begin
    state_nx = err_hit ? S_ERR : S_OK;
    HRESP = (state == S_ERR) | err_hit;
    HREADYOUT = ~err_hit & ~(wr_din & in_full & ~in_pop);
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_reg <= '0;
      enc_dec <= 1'b0;
      key1 <= '0;
      key2 <= '0;
      key3 <= '0;
      key_load <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (HREADY) begin
        ph_valid <= HSEL & HTRANS[1];
        ph_write <= HWRITE;
        ph_reg <= HADDR[14:10];
      end
      if (wr_ctrl) enc_dec <= HWDATA[0];
      if (wr & (ph_reg == 5'd1)) key1 <= HWDATA;
      if (wr & (ph_reg == 5'd2)) key2 <= HWDATA;
      if (wr & (ph_reg == 5'd3)) key3 <= HWDATA;
      key_load <= wr_key;
      underflow <= ~clr & (underflow | err_hit);
    end
  ahb_crypt_fifo #(.W(DATA_W), .D(IN_DEPTH)) u_in (
    .clk(HCLK), .rst(HRESET), .clr(clr), .push(in_push), .pop(in_pop),
    .wdata(HWDATA), .rdata(core_in_data), .count(in_cnt), .full(in_full), .empty(in_empty)
  );
  ahb_crypt_fifo #(.W(DATA_W), .D(OUT_DEPTH)) u_out (
    .clk(HCLK), .rst(HRESET), .clr(clr), .push(out_push), .pop(out_pop),
    .wdata(core_out_data), .rdata(out_head), .count(out_cnt), .full(out_full), .empty(out_empty)
  );
endmodule

// File: tb/tb_ahb_crypt_slave.sv
// tb_ahb_crypt_slave: scoreboard bench with a queue-based reference model of the crypt slave
module tb_ahb_crypt_slave;
  localparam int DW = 64;
  localparam int IN_D = 4;
  localparam int OUT_D = 4;
  logic HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0;
  logic [31:0] HADDR = 0;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 3'd3;
  logic [DW-1:0] HWDATA = 0;
  logic HREADY, HREADYOUT, HRESP, enc_dec, key_load;
  logic [DW-1:0] HRDATA, key1, key2, key3, core_in_data;
  logic core_in_valid, core_in_ready = 0, core_out_valid = 0, core_out_ready;
  logic [DW-1:0] core_out_data = 0;
  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_crypt_slave #(.DATA_W(DW), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .enc_dec(enc_dec),
    .key1(key1), .key2(key2), .key3(key3), .key_load(key_load),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_data(core_out_data)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic resp;
    int waits;
    bit rd;
    bit key;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  logic [DW-1:0] exp_core[$];
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] m_key [3];
  logic m_enc = 0;
  bit m_under = 0;
  int checks = 0, errors = 0, waits = 0;
  bit run = 0, dp_active = 0, kl_exp = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] status_m();
    logic [DW-1:0] s = '0;
    s[7:0] = 8'(in_q.size());
    s[15:8] = 8'(out_q.size());
    s[16] = (in_q.size() == IN_D);
    s[17] = (out_q.size() == 0);
    s[18] = m_under;
    return s;
  endfunction

  // monitor: pops expected bus responses and core-side data as the DUT presents them
  always @(negedge HCLK) begin
    if (HRESET) begin
      kl_exp = 0;
      waits = 0;
    end else if (run) begin
      chk1("key_load", key_load, kl_exp);
      kl_exp = 0;
      if (core_in_valid && core_in_ready) begin
        chk1("core_pop_expected", exp_core.size() > 0, 1'b1);
        if (exp_core.size() > 0) chk("core_in_data", core_in_data, exp_core.pop_front());
      end
      if (dp_active) begin
        chk1("bus_resp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk1("HRESP", HRESP, exp_q[0].resp);
          if (!HREADYOUT) waits++;
          else begin
            me = exp_q.pop_front();
            chk("wait_states", DW'(waits), DW'(me.waits));
            waits = 0;
            if (me.rd) chk("HRDATA", HRDATA, me.data);
            kl_exp = me.key;
          end
        end
      end
    end
  end

  task automatic xfer(input bit wr, input int rg, input logic [DW-1:0] wd, input int rdy_at,
                      input bit cpush, input logic [DW-1:0] cdata);
    exp_t e;
    bit ofull, done;
    int k;
    e.data = '0; e.resp = 0; e.waits = 0; e.rd = !wr; e.key = 0;
    ofull = (out_q.size() == OUT_D);
    if (wr) begin
      case (rg)
        0: begin
          m_enc = wd[0];
          if (wd[1]) begin in_q.delete(); out_q.delete(); m_under = 0; end
        end
        1, 2, 3: begin m_key[rg-1] = wd; e.key = 1; end
        4: begin
          if (in_q.size() == IN_D) e.waits = rdy_at;
          if (rdy_at == 0 || (rdy_at > 0 && in_q.size() == IN_D))
            if (in_q.size() > 0) exp_core.push_back(in_q.pop_front());
          in_q.push_back(wd);
        end
        default: ;
      endcase
    end else begin
      case (rg)
        0: e.data = DW'(m_enc);
        5: if (out_q.size() > 0) e.data = out_q.pop_front();
           else begin e.resp = 1; e.waits = 1; m_under = 1; end
        6: e.data = status_m();
        default: ;
      endcase
    end
    if (cpush && !ofull && !(wr && rg == 0 && wd[1])) out_q.push_back(cdata);
    exp_q.push_back(e);
    HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = 32'(rg) << 10;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 0; HWDATA = wd; dp_active = 1;
    k = 0;
    forever begin
      core_in_ready = (k == rdy_at);
      core_out_valid = cpush && k == 0;
      core_out_data = cdata;
      @(negedge HCLK);
      done = HREADYOUT;
      @(posedge HCLK); #1;
      if (done) break;
      if (k == 40) begin chk1("xfer_complete", done, 1'b1); break; end
      k++;
    end
    dp_active = 0; core_in_ready = 0; core_out_valid = 0;
  endtask

  task automatic core_push(input logic [DW-1:0] d);
    chk1("core_out_ready", core_out_ready, out_q.size() < OUT_D);
    if (out_q.size() < OUT_D) out_q.push_back(d);
    core_out_valid = 1; core_out_data = d;
    @(posedge HCLK); #1;
    core_out_valid = 0;
  endtask

  task automatic core_pop(input int n);
    for (int i = 0; i < n; i++) begin
      chk1("core_in_valid", core_in_valid, in_q.size() > 0);
      if (in_q.size() > 0) exp_core.push_back(in_q.pop_front());
      core_in_ready = 1;
      @(posedge HCLK); #1;
    end
    core_in_ready = 0;
  endtask

  task automatic do_reset(input int n);
    HRESET = 1;
    repeat (n) @(posedge HCLK);
    #1;
    HRESET = 0;
    in_q.delete(); out_q.delete(); exp_core.delete(); exp_q.delete();
    m_under = 0; m_enc = 0;
    for (int i = 0; i < 3; i++) m_key[i] = '0;
  endtask

  task automatic chk_state();
    chk1("enc_dec", enc_dec, m_enc);
    chk("key1", key1, m_key[0]);
    chk("key2", key2, m_key[1]);
    chk("key3", key3, m_key[2]);
  endtask

  task automatic chk_after_reset();
    chk1("rst_HREADYOUT", HREADYOUT, 1'b1);
    chk1("rst_HRESP", HRESP, 1'b0);
    chk("rst_HRDATA", HRDATA, '0);
    chk1("rst_core_in_valid", core_in_valid, 1'b0);
    chk1("rst_core_out_ready", core_out_ready, 1'b1);
    chk1("rst_key_load", key_load, 1'b0);
    chk_state();
  endtask

  initial begin
    int op, rdy;
    do_reset(3);
    run = 1;
    chk_after_reset();
    xfer(1, 0, 64'h1, -1, 0, 0);
    xfer(1, 1, 64'h6b776c6f70617772, -1, 0, 0);
    xfer(1, 2, 64'h64736b65776a7272, -1, 0, 0);
    xfer(1, 3, 64'h736865726c6f636b, -1, 0, 0);
    chk_state();
    for (int i = 0; i <= IN_D; i++)
      xfer(1, 4, 64'h8fe0d9c6b3674857 + DW'(i), (i == IN_D) ? 3 : -1, 0, 0);
    xfer(0, 6, 0, -1, 0, 0);
    core_pop(IN_D + 1);
    xfer(0, 6, 0, -1, 0, 0);
    xfer(0, 5, 0, -1, 0, 0);
    xfer(0, 6, 0, -1, 0, 0);
    xfer(1, 0, 64'h3, -1, 0, 0);
    xfer(0, 6, 0, -1, 0, 0);
    xfer(0, 0, 0, -1, 0, 0);
    for (int i = 0; i < OUT_D - 1; i++) core_push(rnd());
    xfer(0, 6, 0, -1, 0, 0);
    xfer(0, 5, 0, -1, 1, 64'h40a1e8d9e4732dd5);
    xfer(0, 6, 0, -1, 0, 0);
    for (int i = 0; i < OUT_D - 1; i++) xfer(0, 5, 0, -1, 0, 0);
    for (int i = 0; i <= OUT_D; i++) core_push(rnd());
    xfer(0, 6, 0, -1, 0, 0);
    for (int i = 0; i < OUT_D; i++) xfer(0, 5, 0, -1, 0, 0);
    for (int i = 0; i < IN_D; i++) xfer(1, 4, rnd(), -1, 0, 0);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h1000;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 0; HWDATA = rnd();
    @(posedge HCLK); #1;
    chk1("stall_before_reset", HREADYOUT, 1'b0);
    do_reset(1);
    chk_after_reset();
    xfer(0, 6, 0, -1, 0, 0);
    xfer(1, 1, rnd(), -1, 0, 0);
    xfer(1, 4, rnd(), -1, 0, 0);
    xfer(0, 7, 0, -1, 0, 0);
    xfer(1, 7, rnd(), -1, 0, 0);
    xfer(0, 1, 0, -1, 0, 0);
    xfer(0, 4, 0, -1, 0, 0);
    xfer(1, 6, rnd(), -1, 0, 0);
    xfer(1, 5, rnd(), -1, 0, 0);
    HSEL = 1; HWRITE = 1; HADDR = 32'h1000;
    for (int t = 0; t < 2; t++) begin
      HTRANS = 2'(t);
      @(posedge HCLK); #1;
      chk1("idle_HREADYOUT", HREADYOUT, 1'b1);
      chk1("idle_HRESP", HRESP, 1'b0);
      chk("idle_HRDATA", HRDATA, '0);
    end
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 0;
    xfer(0, 6, 0, -1, 0, 0);
    chk_state();
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 12);
      case (op)
        0: xfer(1, 0, DW'($urandom_range(0, 1)) | (($urandom_range(0, 7) == 0) ? DW'(2) : DW'(0)), -1, 0, 0);
        1: xfer(1, $urandom_range(1, 3), rnd(), -1, 0, 0);
        2, 3: begin
          if (in_q.size() == IN_D) rdy = $urandom_range(0, 3);
          else rdy = ($urandom_range(0, 1) == 1) ? 0 : -1;
          xfer(1, 4, rnd(), rdy, 0, 0);
        end
        4: xfer(0, 5, 0, -1, $urandom_range(0, 1) == 1, rnd());
        5: xfer(0, 6, 0, -1, 0, 0);
        6: core_push(rnd());
        7: core_pop($urandom_range(1, 3));
        8: xfer($urandom_range(0, 1) == 1, $urandom_range(7, 31), rnd(), -1, 0, 0);
        9: xfer(0, $urandom_range(1, 4), 0, -1, 0, 0);
        10: xfer(1, $urandom_range(5, 6), rnd(), -1, 0, 0);
        11: xfer(0, 0, 0, -1, 0, 0);
        default: begin @(posedge HCLK); #1; end
      endcase
    end
    xfer(0, 6, 0, -1, 0, 0);
    chk_state();
    @(posedge HCLK); #1;
    chk("bus_queue_drained", DW'(exp_q.size()), '0);
    chk("core_queue_drained", DW'(exp_core.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
